// File: rtl/fir3tap_approx.sv
// 3-tap direct-form FIR with floor shift and 16-bit saturation on a registered output.
// Optional macro APPROX_ADD_EN swaps both tap-sum adders for a lower-part-OR approximate adder.
module fir3tap_approx #(
  parameter logic signed [15:0] H0          = 16'sd1,
  parameter logic signed [15:0] H1          = 16'sd2,
  parameter logic signed [15:0] H2          = 16'sd1,
  parameter int                 SHIFT       = 2,
  parameter int                 ACC_W       = 34,
  parameter int                 APPROX_BITS = 2
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic [15:0] x,
  output logic [15:0] y
);

`ifdef APPROX_ADD_EN
  localparam int LOW_BITS = APPROX_BITS;
`else
  localparam int LOW_BITS = APPROX_BITS * 0;
`endif

  // With LOW_BITS=0 the mask is empty and the adder is an exact add.
  localparam logic [ACC_W-1:0] LOW_MASK = (ACC_W'(1) << LOW_BITS) - ACC_W'(1);

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

  function automatic logic [ACC_W-1:0] tap_add(input logic [ACC_W-1:0] a,
                                               input logic [ACC_W-1:0] b);
    logic [ACC_W-1:0] hi;
    hi = (a & ~LOW_MASK) + (b & ~LOW_MASK);
    return hi | ((a | b) & LOW_MASK);
  endfunction

  function automatic logic [ACC_W-1:0] tap_prod(input logic [15:0] h,
                                                input logic [15:0] v);
    logic signed [31:0] p;
    p = $signed({{16{h[15]}}, h}) * $signed({{16{v[15]}}, v});
    return {{(ACC_W-32){p[31]}}, p};
  endfunction

  logic [15:0] x1_q, x1_d;
  logic [15:0] x2_q, x2_d;
  logic [15:0] y_q, y_d;

  logic [ACC_W-1:0]        p0, p1, p2, s1, s;
  logic signed [ACC_W-1:0] r;

  always_comb begin
    x1_d = x;
    x2_d = x1_q;
    p0   = tap_prod(H0, x);
    p1   = tap_prod(H1, x1_q);
    p2   = tap_prod(H2, x2_q);
    s1   = tap_add(p0, p1);
    s    = tap_add(s1, p2);
    r    = $signed(s) >>> SHIFT;
    if (r > SAT_MAX) begin
      y_d = 16'h7fff;
    end else if (r < SAT_MIN) begin
      y_d = 16'h8000;
    end else begin
      y_d = r[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rstN) begin
      x1_q <= '0;
      x2_q <= '0;
      y_q  <= '0;
    end else begin
      x1_q <= x1_d;
      x2_q <= x2_d;
      y_q  <= y_d;
    end
  end

  assign y = y_q;

endmodule

// File: tb/tb_fir3tap_approx.sv
// Scoreboard bench for fir3tap_approx: default, saturating and unity-coefficient instances.
module tb_fir3tap_approx;

  typedef struct {
    int                 dut;
    logic signed [15:0] exp;
    string              name;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst_v [3];
  logic signed [15:0] x_v   [3];
  logic signed [15:0] y_v   [3];

  exp_t sb[$];
  int   num_checks = 0;
  int   num_errors = 0;

  always #5 clk = ~clk;

  fir3tap_approx u_dut_def (
    .clk (clk), .rstN(rst_v[0]), .x(x_v[0]), .y(y_v[0])
  );

  fir3tap_approx #(
    .H0(16'sd2), .H1(16'sd2), .H2(16'sd2), .SHIFT(0)
  ) u_dut_sat (
    .clk (clk), .rstN(rst_v[1]), .x(x_v[1]), .y(y_v[1])
  );

  fir3tap_approx #(
    .H0(16'sd1), .H1(16'sd1), .H2(16'sd1), .SHIFT(0), .APPROX_BITS(2)
  ) u_dut_apx (
    .clk (clk), .rstN(rst_v[2]), .x(x_v[2]), .y(y_v[2])
  );

  task automatic applyStimulus(input int dut, input logic rst, input logic signed [15:0] xin,
                               input logic chk, input logic signed [15:0] exp,
                               input string name);
    exp_t e;
    rst_v[dut] = rst;
    x_v[dut]   = xin;
    if (chk) begin
      e.dut  = dut;
      e.exp  = exp;
      e.name = name;
      sb.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic checkOutput(input exp_t e);
    num_checks++;
    if (y_v[e.dut] !== e.exp) begin
      num_errors++;
      $display("[TB] FAIL %s (dut %0d): got %0d, expected %0d", e.name, e.dut, y_v[e.dut], e.exp);
    end
  endtask

  // Each pushed expectation belongs to the edge right after it was pushed.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      checkOutput(sb.pop_front());
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int imp_x [5] = '{4, 0, 0, 0, 0};
    int imp_y [5] = '{1, 2, 1, 0, 0};
    int step_y[5] = '{25, 75, 100, 100, 100};
    int neg_y [5] = '{-8192, -24576, -32768, -32768, -32768};
    int flr_x [4] = '{-1, 0, 0, 0};
    int flr_y [4] = '{-1, -1, -1, 0};
    int lin_y [3] = '{200, 400, 600};
    int four_y[3] = '{4, 8, 12};
`ifdef APPROX_ADD_EN
    int one_y [3] = '{1, 1, 1};
`else
    int one_y [3] = '{1, 2, 3};
`endif

    for (int d = 0; d < 3; d++) begin
      rst_v[d] = 1'b1;
      x_v[d]   = 16'sd0;
    end
    @(negedge clk);
    $display("[TB] start");

    for (int i = 0; i < 10; i++) applyStimulus(0, 1'b1, 16'sd1234, 1'b1, 16'sd0, "reset_hold");
    for (int i = 0; i < 3; i++)  applyStimulus(0, 1'b0, 16'sd0, 1'b1, 16'sd0, "reset_release_zero");

    for (int i = 0; i < 5; i++)
      applyStimulus(0, 1'b0, 16'(imp_x[i]), 1'b1, 16'(imp_y[i]), "impulse");

    applyStimulus(0, 1'b1, 16'sd0, 1'b1, 16'sd0, "step_pre_reset");
    for (int i = 0; i < 5; i++)
      applyStimulus(0, 1'b0, 16'sd100, 1'b1, 16'(step_y[i]), "step_100");

    applyStimulus(0, 1'b1, 16'sd100, 1'b1, 16'sd0, "midstream_reset");
    for (int i = 0; i < 3; i++)
      applyStimulus(0, 1'b0, 16'sd100, 1'b1, 16'(step_y[i]), "ramp_after_reset");

    applyStimulus(0, 1'b1, 16'sd0, 1'b1, 16'sd0, "neg_pre_reset");
    for (int i = 0; i < 5; i++)
      applyStimulus(0, 1'b0, -16'sd32768, 1'b1, 16'(neg_y[i]), "step_min");

    applyStimulus(0, 1'b1, 16'sd0, 1'b1, 16'sd0, "floor_pre_reset");
    for (int i = 0; i < 4; i++)
      applyStimulus(0, 1'b0, 16'(flr_x[i]), 1'b1, 16'(flr_y[i]), "floor_shift");
    applyStimulus(0, 1'b1, 16'sd0, 1'b0, 16'sd0, "");

    applyStimulus(1, 1'b1, 16'sd0, 1'b1, 16'sd0, "sat_reset");
    for (int i = 0; i < 3; i++)
      applyStimulus(1, 1'b0, 16'sd100, 1'b1, 16'(lin_y[i]), "sat_linear");
    applyStimulus(1, 1'b1, 16'sd0, 1'b1, 16'sd0, "sat_reset2");
    for (int i = 0; i < 4; i++)
      applyStimulus(1, 1'b0, 16'sd20000, 1'b1, 16'sd32767, "sat_pos");
    applyStimulus(1, 1'b1, 16'sd0, 1'b1, 16'sd0, "sat_reset3");
    for (int i = 0; i < 4; i++)
      applyStimulus(1, 1'b0, -16'sd20000, 1'b1, -16'sd32768, "sat_neg");
    applyStimulus(1, 1'b1, 16'sd0, 1'b0, 16'sd0, "");

    applyStimulus(2, 1'b1, 16'sd0, 1'b1, 16'sd0, "apx_reset");
    for (int i = 0; i < 3; i++)
      applyStimulus(2, 1'b0, 16'sd1, 1'b1, 16'(one_y[i]), "apx_ones");
    applyStimulus(2, 1'b1, 16'sd0, 1'b1, 16'sd0, "apx_reset2");
    for (int i = 0; i < 3; i++)
      applyStimulus(2, 1'b0, 16'sd4, 1'b1, 16'(four_y[i]), "apx_fours");

    applyStimulus(2, 1'b1, 16'sd0, 1'b0, 16'sd0, "");
    @(negedge clk);
    num_checks++;
    if (sb.size() != 0) begin
      num_errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule

// File: doc/fir3tap_approx.md
Name: fir3tap_approx

Overview:
- 3-tap direct-form FIR filter on a signed 16-bit sample stream, one new sample per clock.
- Used as the ECG signal-path filter, where the tap-sum adders may be swapped for approximate adders to measure MSE and area trade-offs.
- Computes y = sat16((H0·x[n] + H1·x[n-1] + H2·x[n-2]) >>> SHIFT) into a registered output.

Parameters:
- H0, 1, signed 16-bit coefficient for the current sample.
- H1, 2, signed 16-bit coefficient for the sample delayed by one.
- H2, 1, signed 16-bit coefficient for the sample delayed by two.
- SHIFT, 2, arithmetic right shift (0..15) applied to the full sum; the default set gives unity DC gain.
- ACC_W, 34, accumulator width in bits; must be at least 34.
- APPROX_BITS, 2, number of low accumulator bits handled by the approximate adder (0..8); used only when the macro is defined.

Ports:
- clk  in  1  rising-edge clock.
- rstN  in  1  synchronous reset, active-high despite the name: 1 = reset.
- x  in  16  signed input sample, sampled on every rising edge.
- y  out  16  signed filtered output, registered.

Behaviour:
- Reset (rstN=1 at a rising edge): the delay registers x1 and x2 and the output y all clear to 0.
  - Reset takes priority over the sample update.
  - Reset in mid-stream discards all history; the first samples after release see zeros in the delay line.
- Normal edge, all three updates at the same edge:
  - x1 <= x
  - x2 <= x1
  - y <= f(x, x1, x2), using the pre-edge values of x1 and x2.
- Latency: y reflects the x presented before edge k starting at edge k. There is one register stage and no valid/ready handshake; every cycle is valid.
- Arithmetic:
  - Products p_i = H_i · tap_i, signed 16×16 giving 32 bits, sign-extended to ACC_W.
  - s1 = p0 + p1, then s = s1 + p2. Both additions are ACC_W-bit signed, using the shared adder function.
  - r = s >>> SHIFT (arithmetic, so it floors toward −∞).
  - Saturate: r > 32767 gives 32767; r < −32768 gives −32768; otherwise y = r[15:0].
  - No wrap-around is permitted on y.
- Coefficients are static; changing them needs re-elaboration.
- Output y changes only on clock edges and has no combinational path from x.

Optional Feature:
- Macro APPROX_ADD_EN.
- Defined: both tap-sum additions use the lower-part-OR approximate adder.
  - Result bits [APPROX_BITS-1:0] = a | b (bitwise OR).
  - Upper bits = a[ACC_W-1:APPROX_BITS] + b[ACC_W-1:APPROX_BITS] with carry-in 0; no carry is propagated out of the low part.
  - APPROX_BITS=0 degenerates to exact addition.
- Undefined: both additions are exact two's-complement ACC_W-bit adds, and APPROX_BITS is ignored.
- Products, shift and saturation are identical in both builds.

Test Plan:
- Reset:
  - Hold rstN=1 for 10 cycles with x=1234 → y=0 throughout.
  - Release, then drive x=0 → y stays 0.
- Impulse, defaults, exact build:
  - Drive x=4 for one cycle, then 0.
  - Expected y on the following edges: 1, 2, 1, 0, 0.
- Step, exact build:
  - Drive x=100 continuously from reset release.
  - Expected y: 25, 75, 100, 100…
  - With x=−32768 held: y settles at −32768 with no overflow.
- Saturation, with H0=H1=H2=2 and SHIFT=0:
  - Hold x=20000 → y = 32767 from the first edge onward.
  - Hold x=−20000 → y = −32768.
- Reset mid-stream:
  - After a step of 100 has settled, assert rstN=1 for one edge → y=0.
  - Release with x=100 still applied → y re-ramps 25, 75, 100.
- Approximate build, with APPROX_ADD_EN defined, H0=H1=H2=1, SHIFT=0, APPROX_BITS=2:
  - Hold x=1 → y sequence 1, 1, 1 (the exact build gives 1, 2, 3).
  - Hold x=4 → y sequence 4, 8, 12, identical to the exact build.
